fifo_pack_writer: RTL
=====================

Name: fifo_pack_writer

Overview:
- Write-side front end for the team's synchronous BRAM FIFO (fifo_sync).
- Accepts a narrow valid/ready sample stream and packs PACK_RATIO consecutive samples into one wide FIFO word.
- Drives the FIFO write port. fifo_sync does not guard writes against full, so this block guarantees no write is ever issued while fifo_full is high.
- Sits between ADC/SPI sample capture logic and the FIFO that the PS-side reader drains.

Parameters:
- IN_WIDTH, 16: width of one input sample.
- PACK_RATIO, 4: samples per FIFO word; must be ≥2.
- PAD_VALUE, 16'h0000: fill value for unused lanes on a flush; IN_WIDTH bits.
- CNT_WIDTH, 16: width of the words_written counter.
- Derived localparams: OUT_WIDTH = IN_WIDTH*PACK_RATIO; LANE_W = clog2(PACK_RATIO).

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset; shared with the attached FIFO.
- s_data  in  IN_WIDTH  input sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  block can accept a sample.
- flush  in  1  single-cycle request to emit a partially filled word.
- flush_done  out  1  one-cycle pulse when the flush completes.
- fifo_wr_data  out  OUT_WIDTH  packed word to the FIFO (OUT_WIDTH+PACK_RATIO bits with the optional feature).
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full flag.
- lane_count  out  LANE_W  samples currently held in the assembly register.
- words_written  out  CNT_WIDTH  count of FIFO writes issued.

Behaviour:
- Reset (resetn=0 at posedge clk):
  - Clears the assembly register, lane index, pending register and counter; state goes to FILL.
  - Outputs during and after reset: s_ready=1, fifo_wr_en=0, flush_done=0, lane_count=0, words_written=0.
  - Reset mid-operation silently discards any partial or pending word.
- Packing:
  - A beat is accepted when s_valid & s_ready.
  - The sample goes into lane[lane_idx]. Lane 0 is bits [IN_WIDTH-1:0]; lane k is bits [(k+1)*IN_WIDTH-1 : k*IN_WIDTH].
  - lane_idx increments after each beat and wraps to 0 after PACK_RATIO-1.
- Completion: accepting a beat in lane PACK_RATIO-1 copies the full word (including that beat) into the pending register on the same edge and sets pend_valid.
- Write issue:
  - fifo_wr_en = pend_valid & ~fifo_full (combinational); fifo_wr_data = pending register.
  - pend_valid clears on the edge where the write is issued, unless a new word completes on that same edge, in which case it stays set with the new data.
  - Data therefore reaches the FIFO 1 cycle after the last sample is accepted, at the earliest.
- Backpressure:
  - s_ready = (state==FILL) & ~(pend_valid & fifo_full & lane_idx==PACK_RATIO-1).
  - Lanes 0..PACK_RATIO-2 keep filling while the FIFO is full. Sustained throughput is 1 sample/cycle.
- State machine (FILL, FLUSH_WAIT):
  - FILL, flush=1, lane_idx (after any beat accepted this cycle) ==0: no-op; flush_done pulses next cycle.
  - FILL, flush=1, lane_idx>0, pending slot free this cycle (pend_valid=0, or the write is issued this cycle): unused lanes are filled with PAD_VALUE and the word moves to pending; lane_idx=0; flush_done pulses next cycle.
  - Otherwise (pending slot busy and fifo_full): go to FLUSH_WAIT; s_ready=0.
  - FLUSH_WAIT exits to FILL when the pending write issues: the padded word moves to pending and flush_done pulses.
  - A beat accepted in the same cycle as flush is packed before padding.
  - flush while in FLUSH_WAIT is ignored.
- Counter: words_written increments on every fifo_wr_en cycle and wraps modulo 2^CNT_WIDTH.

Optional Feature:
- Macro: PACK_WRITER_VALID_MASK_EN.
- Defined:
  - fifo_wr_data is OUT_WIDTH+PACK_RATIO bits; the top PACK_RATIO bits are a lane-valid mask (bit k=1 means lane k holds real data).
  - Full word mask: all ones. Flushed word: ones for the filled lanes only.
  - The attached FIFO DATA_WIDTH must match.
- Undefined: fifo_wr_data is OUT_WIDTH bits; padded lanes cannot be distinguished from data.

Decomposition:
- Shared package/include: FILL/FLUSH_WAIT state encodings, clog2 function, and the OUT_WIDTH and mask-width derivation so the FIFO instantiation uses identical widths.
- No sub-module needed. The block instantiates nothing; the top level wires it to fifo_sync.

Test Plan:
- Stream 0x1111,0x2222,0x3333,0x4444 with fifo_full=0 -> one write, fifo_wr_data=64'h4444_3333_2222_1111 one cycle after the 4th beat; words_written=1.
- Continuous 16 beats at s_valid=1 -> s_ready stays 1; 4 writes on consecutive 4-cycle boundaries; no gaps.
- Hold fifo_full=1 after first word completes, stream 4 more -> 3 more beats accepted, s_ready=0 on the 4th; fifo_wr_en=0 throughout; release full -> first word written, then second, in order.
- Send 0xAAAA,0xBBBB, then pulse flush -> fifo_wr_data=64'h0000_0000_BBBB_AAAA (mask 4'b0011 with the feature); flush_done pulses; lane_count=0.
- Flush with lane_count=0 -> no write, flush_done next cycle. Flush with pend_valid=1 and fifo_full=1 -> FLUSH_WAIT and s_ready=0 until full drops.
- Assert resetn=0 with lane_count=2 and pend_valid=1 -> no write issued, all outputs at reset values next cycle; a new stream packs from lane 0.

Source files
------------

// File: rtl/fifo_pack_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pack_writer_pkg
// Brief   : Shared state encodings, clog2 helper and FIFO word width
//           derivation for fifo_pack_writer and the fifo_sync it feeds.
//           The lane-valid mask is enabled by PACK_WRITER_VALID_MASK_EN.
// Rev     : 1.0 - initial release
// ============================================================================
package fifo_pack_writer_pkg;

  // Packing state machine encodings
  localparam logic [0:0] c_ST_FILL       = 1'b0;
  localparam logic [0:0] c_ST_FLUSH_WAIT = 1'b1;

`ifdef PACK_WRITER_VALID_MASK_EN
  localparam bit c_MASK_EN = 1'b1;
`else
  localparam bit c_MASK_EN = 1'b0;
`endif

  // Ceiling log2, minimum result 0
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of the packed sample payload
  function automatic int pack_out_width(input int in_width, input int pack_ratio);
    return in_width * pack_ratio;
  endfunction

  // Width of the lane-valid mask (zero when the mask is not built)
  function automatic int pack_mask_width(input int pack_ratio);
    return c_MASK_EN ? pack_ratio : 0;
  endfunction

  // Full FIFO write-port width; the FIFO DATA_WIDTH must use this value
  function automatic int pack_wr_width(input int in_width, input int pack_ratio);
    return pack_out_width(in_width, pack_ratio) + pack_mask_width(pack_ratio);
  endfunction

endpackage : fifo_pack_writer_pkg
`default_nettype wire

// File: rtl/fifo_pack_writer.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pack_writer
// Brief   : Packs PACK_RATIO narrow valid/ready samples into one wide word
//           and writes it to fifo_sync, never writing while fifo_full is set.
//           Supports flushing a partially filled word padded with PAD_VALUE.
//           Optional lane-valid mask in the top bits of fifo_wr_data when
//           PACK_WRITER_VALID_MASK_EN is defined.
// Rev     : 1.0 - initial release
// ============================================================================
module fifo_pack_writer
  import fifo_pack_writer_pkg::*;
#(
  parameter int                  IN_WIDTH   = 16,
  parameter int                  PACK_RATIO = 4,
  parameter logic [IN_WIDTH-1:0] PAD_VALUE  = '0,
  parameter int                  CNT_WIDTH  = 16,
  localparam int                 OUT_WIDTH  = pack_out_width(IN_WIDTH, PACK_RATIO),
  localparam int                 LANE_W     = clog2(PACK_RATIO),
  localparam int                 WR_WIDTH   = pack_wr_width(IN_WIDTH, PACK_RATIO)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 flush,
  output logic                 flush_done,
  output logic [WR_WIDTH-1:0]  fifo_wr_data,
  output logic                 fifo_wr_en,
  input  logic                 fifo_full,
  output logic [LANE_W-1:0]    lane_count,
  output logic [CNT_WIDTH-1:0] words_written
);

  logic [0:0]           r_state;
  logic [0:0]           w_state_next;
  logic [OUT_WIDTH-1:0] r_asm;
  logic [LANE_W-1:0]    r_lane_idx;
  logic [WR_WIDTH-1:0]  r_pend;
  logic                 r_pend_valid;
  logic                 r_flush_done;
  logic [CNT_WIDTH-1:0] r_words;

  logic                 w_wr_issue;
  logic                 w_last_lane;
  logic                 w_fill_ready;
  logic                 w_beat;
  logic                 w_complete;
  logic                 w_slot_free;
  logic                 w_flush_partial;
  logic                 w_pad_load;
  logic                 w_flush_done_set;
  logic [LANE_W-1:0]    w_lane_after;
  logic [OUT_WIDTH-1:0] w_asm_next;
  logic [OUT_WIDTH-1:0] w_padded;
  logic [WR_WIDTH-1:0]  w_pend_next;

  // The pending word drains whenever the FIFO has room; gated during reset
  // so a held pending word is never written while the FIFO is being reset.
  assign w_wr_issue  = r_pend_valid & ~fifo_full;
  assign w_last_lane = (r_lane_idx == LANE_W'(PACK_RATIO - 1));
  assign w_slot_free = ~r_pend_valid | w_wr_issue;

  // Only the completing lane stalls on a full FIFO; earlier lanes keep filling.
  assign w_fill_ready = (r_state == c_ST_FILL) & ~(r_pend_valid & fifo_full & w_last_lane);
  assign s_ready      = ~resetn | w_fill_ready;
  assign w_beat       = s_valid & s_ready;
  assign w_complete   = w_beat & w_last_lane;

  // Drop the accepted sample into its lane of the assembly register
  always_comb begin
    w_asm_next = r_asm;
    for (int k = 0; k < PACK_RATIO; k++) begin
      if (w_beat && (r_lane_idx == LANE_W'(k))) begin
        w_asm_next[k*IN_WIDTH +: IN_WIDTH] = s_data;
      end
    end
  end

  // Lane index after this cycle's beat, explicit wrap for non power-of-two ratios
  always_comb begin
    w_lane_after = r_lane_idx;
    if (w_beat) begin
      w_lane_after = w_last_lane ? '0 : r_lane_idx + LANE_W'(1);
    end
  end

  assign w_flush_partial = (w_lane_after != '0);

  // Partial word with every unfilled lane replaced by the pad value
  always_comb begin
    w_padded = w_asm_next;
    for (int k = 0; k < PACK_RATIO; k++) begin
      if (LANE_W'(k) >= w_lane_after) begin
        w_padded[k*IN_WIDTH +: IN_WIDTH] = PAD_VALUE;
      end
    end
  end

`ifdef PACK_WRITER_VALID_MASK_EN
  logic [PACK_RATIO-1:0] w_fill_mask;

  // Mask marks lanes that carry real samples in a flushed word
  always_comb begin
    w_fill_mask = '0;
    for (int k = 0; k < PACK_RATIO; k++) begin
      if (LANE_W'(k) < w_lane_after) begin
        w_fill_mask[k] = 1'b1;
      end
    end
  end

  // Next pending word: completed word with full mask, or padded partial word
  always_comb begin
    w_pend_next = r_pend;
    if (w_complete) begin
      w_pend_next = {{PACK_RATIO{1'b1}}, w_asm_next};
    end else if (w_pad_load) begin
      w_pend_next = {w_fill_mask, w_padded};
    end
  end
`else
  // Next pending word: completed word or padded partial word
  always_comb begin
    w_pend_next = r_pend;
    if (w_complete) begin
      w_pend_next = w_asm_next;
    end else if (w_pad_load) begin
      w_pend_next = w_padded;
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= c_ST_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: park in FLUSH_WAIT when a partial flush finds the slot busy
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_FILL: begin
        if (flush && w_flush_partial && !w_slot_free) begin
          w_state_next = c_ST_FLUSH_WAIT;
        end
      end
      c_ST_FLUSH_WAIT: begin
        if (w_wr_issue) begin
          w_state_next = c_ST_FILL;
        end
      end
      default: w_state_next = c_ST_FILL;
    endcase
  end

  // FSM outputs: when the padded word loads and when the flush completes
  always_comb begin
    w_pad_load       = 1'b0;
    w_flush_done_set = 1'b0;
    case (r_state)
      c_ST_FILL: begin
        if (flush) begin
          if (!w_flush_partial) begin
            w_flush_done_set = 1'b1;
          end else if (w_slot_free) begin
            w_pad_load       = 1'b1;
            w_flush_done_set = 1'b1;
          end
        end
      end
      c_ST_FLUSH_WAIT: begin
        if (w_wr_issue) begin
          w_pad_load       = 1'b1;
          w_flush_done_set = 1'b1;
        end
      end
      default: begin
        w_pad_load       = 1'b0;
        w_flush_done_set = 1'b0;
      end
    endcase
  end

  // Assembly register and lane index; a flush restarts packing at lane 0
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_asm      <= '0;
      r_lane_idx <= '0;
    end else begin
      r_asm      <= w_asm_next;
      r_lane_idx <= w_pad_load ? '0 : w_lane_after;
    end
  end

  // Pending slot: a load on the issue edge keeps the slot occupied
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      if (w_complete || w_pad_load) begin
        r_pend_valid <= 1'b1;
      end else if (w_wr_issue) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Flush-done pulse and write counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_flush_done <= 1'b0;
      r_words      <= '0;
    end else begin
      r_flush_done <= w_flush_done_set;
      if (w_wr_issue) begin
        r_words <= r_words + CNT_WIDTH'(1);
      end
    end
  end

  assign fifo_wr_en    = resetn & w_wr_issue;
  assign fifo_wr_data  = r_pend;
  assign flush_done    = r_flush_done;
  assign lane_count    = r_lane_idx;
  assign words_written = r_words;

endmodule : fifo_pack_writer
`default_nettype wire
